// File: rtl/lif_aer_arbiter.sv
// LIF spike-to-AER arbiter: per-neuron one-entry slots, round-robin grant into a registered event port.
// Latency 1 cycle from slot fill to ev_valid; output holds while ev_valid && !ev_ready, full spikes are dropped.
module lif_aer_arbiter #(
    parameter int N_SRC = 4,
    parameter int TS_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_SRC-1:0] spike_in,
    input  logic             ev_ready,
    input  logic             clr_drop,
    output logic             ev_valid,
    output logic [1:0]       ev_addr,
    output logic [TS_W-1:0]  ev_ts,
    output logic [N_SRC-1:0] pending,
    output logic [7:0]       drop_cnt
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [TS_W-1:0]  slot_q [N_SRC];
    logic [TS_W-1:0]  slot_d [N_SRC];
    logic             vld_q, vld_d;
    logic [1:0]       addr_q, addr_d;
    logic [TS_W-1:0]  ots_q, ots_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       drop_q, drop_d;

    logic             load;
    logic             gnt_vld;
    logic [1:0]       gnt;
    logic [1:0]       cand;
    logic [N_SRC-1:0] consume;
    logic [2:0]       n_drop;
    logic [8:0]       drop_sum;

    assign load = !vld_q || ev_ready;

    // Walk offsets from farthest to nearest so the source right after last_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = last_q;
        cand    = last_q;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (pend_q[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_comb begin
        consume = '0;
        if (load && gnt_vld) begin
            consume[gnt] = 1'b1;
        end
    end

    always_comb begin
        ts_d   = en ? ts_q + 1'b1 : ts_q;
        pend_d = pend_q;
        n_drop = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            slot_d[i] = slot_q[i];
            if (consume[i]) begin
                pend_d[i] = 1'b0;
            end
            if (en && spike_in[i]) begin
                if (!pend_q[i] || consume[i]) begin
                    pend_d[i] = 1'b1;
                    slot_d[i] = ts_q;
                end else begin
                    n_drop = n_drop + 3'd1;
                end
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        ots_d  = ots_q;
        last_d = last_q;
        if (load) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                addr_d = gnt;
                ots_d  = slot_q[gnt];
                last_d = gnt;
            end
        end
    end

    // Clear wins over any drops counted in the same cycle.
    always_comb begin
        drop_sum = {1'b0, drop_q} + {6'd0, n_drop};
        if (clr_drop) begin
            drop_d = 8'd0;
        end else if (drop_sum > 9'd255) begin
            drop_d = 8'd255;
        end else begin
            drop_d = drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            pend_q <= '0;
            vld_q  <= 1'b0;
            addr_q <= 2'd0;
            ots_q  <= '0;
            last_q <= 2'd3;
            drop_q <= 8'd0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            ts_q   <= ts_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
            ots_q  <= ots_d;
            last_q <= last_d;
            drop_q <= drop_d;
            for (int i = 0; i < N_SRC; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign ev_valid = vld_q;
    assign ev_addr  = addr_q;
    assign ev_ts    = ots_q;
    assign pending  = pend_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_lif_aer_arbiter.sv
// Bench for lif_aer_arbiter: directed scenarios with literal expectations, then random traffic vs. a reference model.
module tb_lif_aer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] spike_in = 4'd0;
    logic       ev_ready = 1'b0;
    logic       clr_drop = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_addr;
    logic [7:0] ev_ts;
    logic [3:0] pending;
    logic [7:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: each output event is delivered first, then the surviving spikes fill empty slots.
    int         m_tsc, m_last, m_drop, m_addr, m_ts;
    bit         m_vld;
    logic [3:0] m_pend;
    int         m_slot [4];

    lif_aer_arbiter #(.N_SRC(4), .TS_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .ev_ready(ev_ready), .clr_drop(clr_drop), .ev_valid(ev_valid),
        .ev_addr(ev_addr), .ev_ts(ev_ts), .pending(pending), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_tsc  = 0;
        m_last = 3;
        m_drop = 0;
        m_addr = 0;
        m_ts   = 0;
        m_vld  = 1'b0;
        m_pend = 4'd0;
        for (int i = 0; i < 4; i++) m_slot[i] = 0;
    endfunction

    function automatic void model_step(bit e, logic [3:0] sp, bit rdy, bit clr);
        int g;
        int drops;
        g = -1;
        drops = 0;
        if (!m_vld || rdy) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
            if (g >= 0) begin
                m_vld     = 1'b1;
                m_addr    = g;
                m_ts      = m_slot[g];
                m_pend[g] = 1'b0;
                m_last    = g;
            end else begin
                m_vld = 1'b0;
            end
        end
        if (e) begin
            for (int i = 0; i < 4; i++) begin
                if (sp[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1'b1;
                        m_slot[i] = m_tsc;
                    end else begin
                        drops++;
                    end
                end
            end
            m_tsc = (m_tsc + 1) % 256;
        end
        if (clr) m_drop = 0;
        else     m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    endfunction

    always @(negedge clk) begin
        chk("ev_valid", ev_valid, m_vld);
        if (m_vld) begin
            chk("ev_addr", ev_addr, m_addr);
            chk("ev_ts", ev_ts, m_ts);
        end
        chk("pending", pending, m_pend);
        chk("drop_cnt", drop_cnt, m_drop);
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(en, spike_in, ev_ready, clr_drop);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;

        // Single spike at ts=5
        en = 1'b1;
        ev_ready = 1'b1;
        repeat (5) tick();
        spike_in = 4'b0100;
        tick();
        spike_in = 4'b0000;
        tick();
        chk("single_valid", ev_valid, 1);
        chk("single_addr", ev_addr, 2);
        chk("single_ts", ev_ts, 5);
        tick();
        chk("single_after", ev_valid, 0);

        // Four simultaneous spikes at ts=0
        do_reset();
        spike_in = 4'b1111;
        tick();
        spike_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("simul_valid", ev_valid, 1);
            chk("simul_addr", ev_addr, k);
            chk("simul_ts", ev_ts, 0);
        end
        chk("simul_drop", drop_cnt, 0);
        tick();
        chk("simul_end", ev_valid, 0);

        // Backpressure: held output, buffered second spike, dropped third
        do_reset();
        ev_ready = 1'b0;
        spike_in = 4'b0010;
        tick();
        tick();
        chk("bp_valid", ev_valid, 1);
        chk("bp_addr", ev_addr, 1);
        chk("bp_ts", ev_ts, 0);
        tick();
        chk("bp_drop", drop_cnt, 1);
        chk("bp_hold_ts", ev_ts, 0);
        spike_in = 4'b0000;
        ev_ready = 1'b1;
        tick();
        chk("bp_drain_addr", ev_addr, 1);
        chk("bp_drain_ts", ev_ts, 1);
        tick();
        chk("bp_drain_end", ev_valid, 0);

        // Fairness between sources 0 and 3
        do_reset();
        spike_in = 4'b1001;
        tick();
        for (int n = 1; n < 10; n++) begin
            tick();
            chk("fair_valid", ev_valid, 1);
            chk("fair_addr", ev_addr, (n % 2 == 1) ? 0 : 3);
        end
        spike_in = 4'b0000;
        repeat (3) tick();

        // Timestamp wrap, drop saturation, clear against drops
        do_reset();
        repeat (255) tick();
        spike_in = 4'b0001;
        tick();
        tick();
        chk("wrap_ts255", ev_ts, 255);
        chk("wrap_addr", ev_addr, 0);
        spike_in = 4'b0000;
        tick();
        chk("wrap_ts0_valid", ev_valid, 1);
        chk("wrap_ts0", ev_ts, 0);
        ev_ready = 1'b0;
        spike_in = 4'b1111;
        repeat (100) tick();
        chk("drop_sat", drop_cnt, 255);
        clr_drop = 1'b1;
        tick();
        chk("drop_clr", drop_cnt, 0);
        clr_drop = 1'b0;
        spike_in = 4'b0000;
        ev_ready = 1'b1;
        repeat (6) tick();

        // Asynchronous reset during a stalled handshake
        do_reset();
        ev_ready = 1'b0;
        spike_in = 4'b0010;
        tick();
        spike_in = 4'b0110;
        tick();
        spike_in = 4'b0000;
        chk("mid_pending", pending, 6);
        chk("mid_valid", ev_valid, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", ev_valid, 0);
        chk("arst_addr", ev_addr, 0);
        chk("arst_ts", ev_ts, 0);
        chk("arst_pending", pending, 0);
        chk("arst_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        repeat (5) tick();
        chk("arst_no_stale", ev_valid, 0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            en       = ($urandom_range(0, 9) != 0);
            spike_in = 4'($urandom);
            ev_ready = ($urandom_range(0, 2) != 0);
            clr_drop = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
